// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the instruction-cache refill path.
// Line geometry is derived from the block and beat widths.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE
  } state_e;

  localparam int DEF_PC_SIZE    = 32;
  localparam int DEF_MEM_WORD   = 32;
  localparam int DEF_BLOCK_BITS = 512;

  localparam int WPL = DEF_BLOCK_BITS / DEF_MEM_WORD;

  function automatic int wpl_of(int line_w, int word_w);
    return line_w / word_w;
  endfunction

  function automatic int beat_w(int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int byte_off_w(int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Beat-assembly bank for one cache line plus the registered line
// presented to the cache array, updated only when a refill completes.
module icache_line_buffer
  import icache_pkg::*;
#(
  parameter int LINE_W = DEF_BLOCK_BITS,
  parameter int WORD_W = DEF_MEM_WORD,
  parameter int IDX_W  = beat_w(wpl_of(DEF_BLOCK_BITS, DEF_MEM_WORD))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              commit,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] bank_q;
  logic [LINE_W-1:0] merged;

  always_comb begin
    merged = bank_q;
    merged[int'(idx)*WORD_W +: WORD_W] = wdata;
  end

  // The final beat is folded in on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      line   <= '0;
    end else begin
      if (we)
        bank_q <= merged;
      if (commit)
        line <= merged;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: requests a line from RAM, assembles
// the beats and writes the line back, with flush abort and burst drain.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int PC_SIZE    = DEF_PC_SIZE,
  parameter int MEM_WORD   = DEF_MEM_WORD,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_SIZE-1:0]    pc,
  input  logic                  pc_valid,
  input  logic                  hit,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [PC_SIZE-1:0]    mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [MEM_WORD-1:0]   mem_rdata,
  output logic                  fill_we,
  output logic [PC_SIZE-1:0]    fill_addr,
  output logic [BLOCK_BITS-1:0] fill_line,
  output logic                  stall
);

  localparam int NW = wpl_of(BLOCK_BITS, MEM_WORD);
  localparam int BW = beat_w(NW);
  localparam int CW = BW + 1;
  localparam int OW = byte_off_w(BLOCK_BITS);

  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic [CW-1:0] FULL = CW'(NW);
  localparam logic [PC_SIZE-1:0] MASK =
    ~PC_SIZE'((64'd1 << OW) - 64'd1);

  state_e state_q;
  state_e state_d;

  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      drain_q;
  logic [PC_SIZE-1:0] addr_q;
  logic miss;
  logic draining;
  logic beat;
  logic last_beat;
  logic accept;

  assign miss      = pc_valid & ~hit;
  assign draining  = drain_q != '0;
  assign beat      = (state_q == S_FILL) & mem_rvalid;
  assign last_beat = beat & (cnt_q == LAST);
  assign accept    = (state_q == S_IDLE) & miss
                   & ~draining & ~flush;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (miss & ~draining) state_d = S_REQ;
        S_REQ:   if (mem_gnt) state_d = S_FILL;
        S_FILL:  if (last_beat) state_d = S_WRITE;
        S_WRITE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = 1'b0;
    fill_we = 1'b0;
    stall   = miss | draining;
    unique case (state_q)
      S_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      S_FILL: stall = 1'b1;
      S_WRITE: begin
        fill_we = ~flush;
        stall   = 1'b1;
      end
      default: ;
    endcase
  end

  // Beats still owed by an aborted burst are counted off in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      drain_q <= '0;
      addr_q  <= '0;
    end else begin
      if (accept)
        addr_q <= pc & MASK;
      if ((state_q == S_REQ) & mem_gnt)
        cnt_q <= '0;
      else if (beat)
        cnt_q <= cnt_q + CW'(1);
      if (flush & (state_q == S_FILL))
        drain_q <= FULL - cnt_q - CW'(mem_rvalid);
      else if (flush & (state_q == S_REQ) & mem_gnt)
        drain_q <= FULL;
      else if (draining & mem_rvalid)
        drain_q <= drain_q - CW'(1);
    end
  end

  assign mem_addr  = addr_q;
  assign fill_addr = addr_q;

  icache_line_buffer #(
    .LINE_W (BLOCK_BITS),
    .WORD_W (MEM_WORD),
    .IDX_W  (BW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (beat),
    .commit (last_beat & ~flush),
    .idx    (cnt_q[BW-1:0]),
    .wdata  (mem_rdata),
    .line   (fill_line)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Refill controller bench: directed scenarios and random traffic against
// a transaction-level model, plus a narrow-line instance for geometry.
module tb_icache_refill_ctrl;

  localparam int WPL0 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, pc_valid, hit, flush;
  logic         mem_gnt, mem_rvalid;
  logic [31:0]  pc, mem_rdata;
  logic         mem_req, fill_we, stall;
  logic [31:0]  mem_addr, fill_addr;
  logic [511:0] fill_line;

  logic         b_rst, b_pc_valid, b_hit, b_flush;
  logic         b_mem_gnt, b_mem_rvalid;
  logic [31:0]  b_pc;
  logic [63:0]  b_mem_rdata;
  logic         b_mem_req, b_fill_we, b_stall;
  logic [31:0]  b_mem_addr, b_fill_addr;
  logic [255:0] b_fill_line;

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid),
    .hit(hit), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_addr(fill_addr),
    .fill_line(fill_line), .stall(stall)
  );

  icache_refill_ctrl #(
    .PC_SIZE(32), .MEM_WORD(64), .BLOCK_BITS(256)
  ) dut_b (
    .clk(clk), .rst(b_rst), .pc(b_pc), .pc_valid(b_pc_valid),
    .hit(b_hit), .flush(b_flush), .mem_req(b_mem_req),
    .mem_addr(b_mem_addr), .mem_gnt(b_mem_gnt),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .fill_we(b_fill_we), .fill_addr(b_fill_addr),
    .fill_line(b_fill_line), .stall(b_stall)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int we_cnt = 0;
  int we_cyc = -1;
  int req_cyc = -1;
  int ram_left = 0;

  bit          m_act = 0;
  bit          m_gnt = 0;
  int          m_got = 0;
  int          m_drop = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_beats [WPL0];
  logic [511:0] m_line = '0;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit h,
                      input bit f, input bit g, input bit rv,
                      input logic [31:0] p, input logic [31:0] d);
    bit ereq, ewe, estall;
    rst = r; pc_valid = v; hit = h; flush = f;
    mem_gnt = g; mem_rvalid = rv; pc = p; mem_rdata = d;
    ereq   = m_act && !m_gnt;
    ewe    = m_act && m_gnt && m_got == WPL0 && !f;
    estall = (v && !h) || m_act || m_drop > 0;
    @(negedge clk);
    chk("mem_req", mem_req, ereq);
    chk("fill_we", fill_we, ewe);
    chk("stall", stall, estall);
    chk("mem_addr", mem_addr, m_addr);
    chk("fill_addr", fill_addr, m_addr);
    chk("fill_line", fill_line, m_line);
    if (fill_we) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (mem_req && req_cyc < 0) req_cyc = cyc;
    @(posedge clk);
    if (r) begin
      m_act = 0; m_gnt = 0; m_got = 0; m_drop = 0;
      m_addr = '0; m_line = '0; ram_left = 0;
    end else begin
      if (ereq && g) ram_left = WPL0;
      else if (rv && ram_left > 0) ram_left--;
      if (f) begin
        if (m_act && m_gnt && m_got < WPL0)
          m_drop = WPL0 - m_got - int'(rv);
        else if (m_act && !m_gnt && g)
          m_drop = WPL0;
        else if (!m_act && m_drop > 0 && rv)
          m_drop--;
        m_act = 0;
      end else if (!m_act) begin
        if (m_drop > 0) begin
          if (rv) m_drop--;
        end else if (v && !h) begin
          m_act = 1; m_gnt = 0; m_got = 0;
          m_addr = p & 32'hFFFF_FFC0;
        end
      end else if (!m_gnt) begin
        if (g) begin
          m_gnt = 1; m_got = 0;
        end
      end else if (m_got < WPL0) begin
        if (rv) begin
          m_beats[m_got] = d;
          m_got++;
          if (m_got == WPL0)
            for (int k = 0; k < WPL0; k++)
              m_line[32*k +: 32] = m_beats[k];
        end
      end else begin
        m_act = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic burst(input logic [31:0] p, input int base);
    for (int k = 0; k < WPL0; k++)
      step(0, 1, 0, 0, 0, 1, p, 32'(base + k));
    step(0, 1, 0, 0, 0, 0, p, 0);
  endtask

  initial begin
    logic [511:0] exp35;
    logic [255:0] exp_b;
    int base, miss_cyc, b15, lat;
    bit rv;

    rst = 1; pc_valid = 0; hit = 0; flush = 0;
    mem_gnt = 0; mem_rvalid = 0; pc = '0; mem_rdata = '0;
    b_rst = 1; b_pc_valid = 0; b_hit = 0; b_flush = 0;
    b_mem_gnt = 0; b_mem_rvalid = 0; b_pc = '0; b_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then the basic 16-beat refill
    step(0, 0, 0, 0, 0, 0, 0, 0);
    miss_cyc = cyc;
    step(0, 1, 0, 0, 0, 0, 32'h0000_1234, 0);
    chk("addr35", mem_addr, 32'h0000_1200);
    step(0, 1, 0, 0, 1, 0, 32'h0000_1234, 0);
    burst(32'h0000_1234, 0);
    chk("lat35", we_cyc - miss_cyc, 18);
    for (int k = 0; k < WPL0; k++) exp35[32*k +: 32] = 32'(k);
    chk("line35", fill_line, exp35);
    step(0, 1, 1, 0, 0, 0, 32'h0000_1234, 0);

    // delayed grant, sparse beats
    base = we_cnt;
    step(0, 1, 0, 0, 0, 0, 32'h0000_8a7c, 0);
    repeat (5) step(0, 1, 0, 0, 0, 0, 32'h0000_8a7c, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_8a7c, 0);
    for (int i = 0; i < 2 * WPL0; i++)
      step(0, 1, 0, 0, 0, i[0], 32'h0000_8a7c, 32'h100 + 32'(i));
    step(0, 1, 0, 0, 0, 0, 32'h0000_8a7c, 0);
    step(0, 1, 1, 0, 0, 0, 32'h0000_8a7c, 0);
    chk("we36", we_cnt - base, 1);

    // flush after beat 7, drain, then next miss
    base = we_cnt;
    step(0, 1, 0, 0, 0, 0, 32'h0000_4440, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_4440, 0);
    for (int k = 0; k < 8; k++)
      step(0, 1, 0, 0, 0, 1, 32'h0000_4440, 32'h200 + 32'(k));
    step(0, 1, 0, 1, 0, 0, 32'h0000_5500, 0);
    req_cyc = -1;
    b15 = -1;
    for (int k = 8; k < WPL0; k++) begin
      if (k == WPL0 - 1) b15 = cyc;
      step(0, 1, 0, 0, 0, 1, 32'h0000_5500, 32'h200 + 32'(k));
      step(0, 1, 0, 0, 0, 0, 32'h0000_5500, 0);
    end
    chk("nowe37", we_cnt - base, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_5500, 0);
    chk("req37", req_cyc > b15, 1'b1);
    burst(32'h0000_5500, 32'h300);
    chk("we37", we_cnt - base, 1);

    // flush coinciding with the write cycle
    base = we_cnt;
    step(0, 1, 0, 0, 0, 0, 32'h0000_6000, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_6000, 0);
    for (int k = 0; k < WPL0; k++)
      step(0, 1, 0, 0, 0, 1, 32'h0000_6000, 32'h400 + 32'(k));
    step(0, 0, 0, 1, 0, 0, 32'h0000_6000, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0000_6000, 0);
    chk("we38", we_cnt - base, 0);

    // reset pulsed mid-fill, then a clean refill
    base = we_cnt;
    step(0, 1, 0, 0, 0, 0, 32'h0000_7040, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_7040, 0);
    for (int k = 0; k < 5; k++)
      step(0, 1, 0, 0, 0, 1, 32'h0000_7040, 32'h500 + 32'(k));
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst39", {mem_req, fill_we, stall, mem_addr, fill_addr}, '0);
    chk("rst39_line", fill_line, '0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0000_7040, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0000_7040, 0);
    burst(32'h0000_7040, 32'h600);
    chk("we39", we_cnt - base, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (ram_left > 0) rv = $urandom_range(0, 3) != 0;
      else rv = $urandom_range(0, 9) == 0;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0,
           rv, $urandom, $urandom);
    end

    // 64-bit beats, 256-bit line
    @(posedge clk);
    #1 b_rst = 0;
    @(negedge clk);
    chk("b_reset", {b_mem_req, b_fill_we, b_stall,
                    b_mem_addr, b_fill_addr, b_fill_line}, '0);
    @(posedge clk);
    #1;
    b_pc = 32'h0000_0a64; b_pc_valid = 1; b_hit = 0;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      #1;
      b_mem_gnt    = (n == 1);
      b_mem_rvalid = (n >= 2 && n <= 5);
      b_mem_rdata  = {32'hB000 + 32'(n - 2), 32'hA000 + 32'(n - 2)};
      b_hit        = (n >= 7);
      @(negedge clk);
      if (n == 1) begin
        chk("b_req", b_mem_req, 1'b1);
        chk("b_addr", b_mem_addr, 32'h0000_0a60);
      end
      if (n == 7) chk("b_stall", b_stall, 1'b0);
      if (b_fill_we && lat < 0) lat = n;
      @(posedge clk);
    end
    chk("b_lat", lat, 6);
    for (int k = 0; k < 4; k++)
      exp_b[64*k +: 64] = {32'hB000 + 32'(k), 32'hA000 + 32'(k)};
    chk("b_line", b_fill_line, exp_b);
    chk("b_faddr", b_fill_addr, 32'h0000_0a60);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
